// File: rtl/reg_writeback_if.sv
// Bundle for the register-bank writer: producer handshakes, bank write port and decode lookup.
// The slave side is the writeback queue; the master side is producers, bank and decode.
interface reg_writeback_if #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 5,
    parameter int unsigned DW    = 32
);
    logic                    alu_valid;
    logic [AW-1:0]           alu_addr;
    logic [DW-1:0]           alu_data;
    logic                    alu_ready;
    logic                    mem_valid;
    logic [AW-1:0]           mem_addr;
    logic [DW-1:0]           mem_data;
    logic                    mem_ready;
    logic                    enc;
    logic [AW-1:0]           addrc;
    logic [DW-1:0]           datac;
    logic [AW-1:0]           qaddra;
    logic [AW-1:0]           qaddrb;
    logic                    qhita;
    logic [DW-1:0]           qdataa;
    logic                    qhitb;
    logic [DW-1:0]           qdatab;
    logic [$clog2(DEPTH):0]  count;

    modport master (
        output alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data, qaddra, qaddrb,
        input  alu_ready, mem_ready, enc, addrc, datac, qhita, qdataa, qhitb, qdatab, count
    );

    modport slave (
        input  alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data, qaddra, qaddrb,
        output alu_ready, mem_ready, enc, addrc, datac, qhita, qdataa, qhitb, qdatab, count
    );
endinterface

// File: rtl/reg_writeback.sv
// Register-bank write-port feeder: in-order queue of ALU and load results, one drain per clock.
// Define WB_BYPASS_EN to build the pending-write lookup used for decode forwarding.
module reg_writeback #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 5,
    parameter int unsigned DW    = 32
) (
    input logic            clock,
    input logic            reset,
    reg_writeback_if.slave bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [AW-1:0] addr_q [DEPTH];
    logic [DW-1:0] data_q [DEPTH];
    logic [PW-1:0] head_q;
    logic [PW-1:0] tail_q;
    logic [CW-1:0] count_q;
    logic          mem_push;
    logic          alu_push;
    logic          deq;
    logic [PW-1:0] alu_slot;

    // Readies look only at registered count and mem_valid, never at alu_valid.
    always_comb begin
        bus.mem_ready = count_q < CW'(DEPTH);
        bus.alu_ready = (count_q < CW'(DEPTH - 1)) ||
                        ((count_q == CW'(DEPTH - 1)) && !bus.mem_valid);
    end

    // Writes to register 0 handshake normally but are dropped.
    always_comb begin
        mem_push = bus.mem_valid && bus.mem_ready && (bus.mem_addr != '0);
        alu_push = bus.alu_valid && bus.alu_ready && (bus.alu_addr != '0);
        deq      = count_q != '0;
        alu_slot = tail_q + PW'(mem_push);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_q + PW'(deq);
            tail_q  <= tail_q + PW'(mem_push) + PW'(alu_push);
            count_q <= count_q + CW'(mem_push) + CW'(alu_push) - CW'(deq);
        end
    end

    // Load result is the older of a simultaneous pair, so it takes the tail slot first.
    always_ff @(posedge clock) begin
        if (mem_push) begin
            addr_q[tail_q] <= bus.mem_addr;
            data_q[tail_q] <= bus.mem_data;
        end
        if (alu_push) begin
            addr_q[alu_slot] <= bus.alu_addr;
            data_q[alu_slot] <= bus.alu_data;
        end
    end

    always_comb begin
        bus.enc   = deq;
        bus.addrc = deq ? addr_q[head_q] : '0;
        bus.datac = deq ? data_q[head_q] : '0;
        bus.count = count_q;
    end

`ifdef WB_BYPASS_EN
    // Walk oldest to youngest so the last match (youngest) wins.
    always_comb begin
        bus.qhita  = 1'b0;
        bus.qdataa = '0;
        bus.qhitb  = 1'b0;
        bus.qdatab = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (CW'(i) < count_q) begin
                if ((bus.qaddra != '0) && (addr_q[head_q + PW'(i)] == bus.qaddra)) begin
                    bus.qhita  = 1'b1;
                    bus.qdataa = data_q[head_q + PW'(i)];
                end
                if ((bus.qaddrb != '0) && (addr_q[head_q + PW'(i)] == bus.qaddrb)) begin
                    bus.qhitb  = 1'b1;
                    bus.qdatab = data_q[head_q + PW'(i)];
                end
            end
        end
    end
`else
    logic unused_lookup;

    always_comb begin
        bus.qhita     = 1'b0;
        bus.qdataa    = '0;
        bus.qhitb     = 1'b0;
        bus.qdatab    = '0;
        unused_lookup = ^{bus.qaddra, bus.qaddrb};
    end
`endif
endmodule

// File: tb/tb_reg_writeback.sv
// Bench for reg_writeback: directed vector table, hand sequences and a queue-based reference model.
module tb_reg_writeback;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned AW    = 5;
    localparam int unsigned DW    = 32;
`ifdef WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clock;
    logic reset;
    int   checks;
    int   failures;

    reg_writeback_if #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) bus ();

    reg_writeback #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    ent_t mq[$];

    typedef struct {
        logic          av;
        logic [AW-1:0] aa;
        logic [DW-1:0] ad;
        logic          mv;
        logic [AW-1:0] ma;
        logic [DW-1:0] md;
        logic [AW-1:0] qa;
        logic          e_enc;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_data;
        logic [2:0]    e_cnt;
        logic          e_ardy;
        logic          e_mrdy;
        logic          e_hit;
        logic [DW-1:0] e_qd;
    } vec_t;

    vec_t vt[9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                          input logic mv, input logic [AW-1:0] ma, input logic [DW-1:0] md,
                          input logic [AW-1:0] qa, input logic [AW-1:0] qb);
        bus.alu_valid = av;
        bus.alu_addr  = aa;
        bus.alu_data  = ad;
        bus.mem_valid = mv;
        bus.mem_addr  = ma;
        bus.mem_data  = md;
        bus.qaddra    = qa;
        bus.qaddrb    = qb;
    endtask

    // One clock against the reference queue: check outputs, then apply the edge's effects.
    task automatic model_cycle();
        int            n;
        bit            mr;
        bit            ar;
        bit            ha;
        bit            hb;
        logic [DW-1:0] da;
        logic [DW-1:0] db;
        ent_t          me;
        ent_t          ae;
        bit            mpush;
        bit            apush;
        #1;
        n  = mq.size();
        mr = n < DEPTH;
        ar = (n < DEPTH - 1) || ((n == DEPTH - 1) && !bus.mem_valid);
        ha = 0; hb = 0; da = '0; db = '0;
        if (BYP) begin
            for (int i = 0; i < n; i++) begin
                if (bus.qaddra != 0 && mq[i].a == bus.qaddra) begin ha = 1; da = mq[i].d; end
                if (bus.qaddrb != 0 && mq[i].a == bus.qaddrb) begin hb = 1; db = mq[i].d; end
            end
        end
        chk("m_count", bus.count, n);
        chk("m_count_le_depth", bus.count <= DEPTH, 1);
        chk("m_enc", bus.enc, n != 0);
        chk("m_addrc", bus.addrc, n != 0 ? mq[0].a : 0);
        chk("m_datac", bus.datac, n != 0 ? mq[0].d : 0);
        chk("m_mem_ready", bus.mem_ready, mr);
        chk("m_alu_ready", bus.alu_ready, ar);
        chk("m_qhita", bus.qhita, ha);
        chk("m_qdataa", bus.qdataa, da);
        chk("m_qhitb", bus.qhitb, hb);
        chk("m_qdatab", bus.qdatab, db);
        mpush = bus.mem_valid && mr && bus.mem_addr != 0;
        apush = bus.alu_valid && ar && bus.alu_addr != 0;
        me = '{a: bus.mem_addr, d: bus.mem_data};
        ae = '{a: bus.alu_addr, d: bus.alu_data};
        @(posedge clock);
        if (n != 0) void'(mq.pop_front());
        if (mpush) mq.push_back(me);
        if (apush) mq.push_back(ae);
        #1;
    endtask

    task automatic do_reset();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        mq.delete();
        reset = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clock);
        #1;
        chk("rst_enc", bus.enc, 0);
        chk("rst_count", bus.count, 0);
        chk("rst_addrc", bus.addrc, 0);
        chk("rst_datac", bus.datac, 0);
        chk("rst_qhita", bus.qhita, 0);
        reset = 1'b0;

        // Directed table: single write, dual ordering, register 0.
        vt[0] = '{1, 5, 32'hDEADBEEF, 0, 0, 0, 5, 0, 0, 0, 0, 1, 1, 0, 0};
        vt[1] = '{0, 0, 0, 0, 0, 0, 5, 1, 5, 32'hDEADBEEF, 1, 1, 1, BYP,
                  BYP ? 32'hDEADBEEF : 32'h0};
        vt[2] = '{0, 0, 0, 0, 0, 0, 5, 0, 0, 0, 0, 1, 1, 0, 0};
        vt[3] = '{1, 3, 32'h22, 1, 3, 32'h11, 3, 0, 0, 0, 0, 1, 1, 0, 0};
        vt[4] = '{0, 0, 0, 0, 0, 0, 3, 1, 3, 32'h11, 2, 1, 1, BYP, BYP ? 32'h22 : 32'h0};
        vt[5] = '{0, 0, 0, 0, 0, 0, 3, 1, 3, 32'h22, 1, 1, 1, BYP, BYP ? 32'h22 : 32'h0};
        vt[6] = '{0, 0, 0, 0, 0, 0, 3, 0, 0, 0, 0, 1, 1, 0, 0};
        vt[7] = '{1, 0, 32'h55, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0};
        vt[8] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0};
        for (int i = 0; i < 9; i++) begin
            set_in(vt[i].av, vt[i].aa, vt[i].ad, vt[i].mv, vt[i].ma, vt[i].md,
                   vt[i].qa, vt[i].qa);
            #1;
            chk($sformatf("v%0d_enc", i), bus.enc, vt[i].e_enc);
            chk($sformatf("v%0d_addrc", i), bus.addrc, vt[i].e_addr);
            chk($sformatf("v%0d_datac", i), bus.datac, vt[i].e_data);
            chk($sformatf("v%0d_count", i), bus.count, vt[i].e_cnt);
            chk($sformatf("v%0d_alu_ready", i), bus.alu_ready, vt[i].e_ardy);
            chk($sformatf("v%0d_mem_ready", i), bus.mem_ready, vt[i].e_mrdy);
            chk($sformatf("v%0d_qhita", i), bus.qhita, vt[i].e_hit);
            chk($sformatf("v%0d_qdataa", i), bus.qdataa, vt[i].e_qd);
            chk($sformatf("v%0d_qhitb", i), bus.qhitb, vt[i].e_hit);
            @(posedge clock);
            #1;
        end

        // Async reset mid-drain: build three entries, then reset between edges.
        do_reset();
        set_in(1, 2, 32'h200, 1, 1, 32'h100, 0, 0);
        model_cycle();
        set_in(1, 4, 32'h400, 1, 3, 32'h300, 3, 4);
        model_cycle();
        set_in(0, 0, 0, 0, 0, 0, 3, 4);
        #1;
        chk("pre_rst_count", bus.count, 3);
        #1;
        reset = 1'b1;
        #1;
        chk("arst_enc", bus.enc, 0);
        chk("arst_count", bus.count, 0);
        chk("arst_addrc", bus.addrc, 0);
        chk("arst_datac", bus.datac, 0);
        chk("arst_qhita", bus.qhita, 0);
        chk("arst_qdataa", bus.qdataa, 0);
        mq.delete();
        #1;
        reset = 1'b0;
        set_in(1, 9, 32'h900, 0, 0, 0, 9, 0);
        model_cycle();
        set_in(0, 0, 0, 0, 0, 0, 9, 9);
        model_cycle();
        model_cycle();

        // Backpressure: keep both producers busy so the queue runs near full.
        for (int i = 0; i < 8; i++) begin
            set_in(1, AW'(2 * i + 2), DW'(32'hA00 + i), 1, AW'(2 * i + 1), DW'(32'hB00 + i),
                   AW'(2 * i + 1), AW'(2 * i));
            model_cycle();
        end
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (5) model_cycle();

        // Pointer wrap: ten alternating mem/alu entries.
        for (int i = 1; i <= 10; i++) begin
            if (i % 2 == 1) set_in(0, 0, 0, 1, AW'(i), DW'(i * 32'h100), AW'(i), 0);
            else            set_in(1, AW'(i), DW'(i * 32'h100), 0, 0, 0, AW'(i - 1), 0);
            model_cycle();
        end
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (4) model_cycle();

        // Randomized traffic with a small address space to force collisions.
        for (int i = 0; i < 400; i++) begin
            set_in(1'($urandom_range(0, 3) != 0), AW'($urandom_range(0, 7)), $urandom,
                   1'($urandom_range(0, 2) != 0), AW'($urandom_range(0, 7)), $urandom,
                   AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
            model_cycle();
        end
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (5) model_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/reg_writeback.md
Name: reg_writeback

Overview:
- Writer side of the processor register bank's single write port.
- Accepts completed results from two producers: the ALU path and the memory-load path.
- Buffers results in a small in-order queue and drains one entry per clock onto the bank's write interface (enc, addrc, datac).
- Provides a pending-write lookup so the decode stage can pick up values not yet committed to the bank.

Parameters:
DEPTH, 4, queue entries (power of two, minimum 2)
AW, 5, register address width
DW, 32, register data width

Ports:
clock  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-high; clears queue and all state
alu_valid  input  1  ALU result offered
alu_addr  input  AW  ALU destination register
alu_data  input  DW  ALU result
alu_ready  output  1  ALU result accepted this cycle when alu_valid also high
mem_valid  input  1  load result offered
mem_addr  input  AW  load destination register
mem_data  input  DW  load result
mem_ready  output  1  load result accepted this cycle when mem_valid also high
enc  output  1  write enable to register bank
addrc  output  AW  write address to register bank
datac  output  DW  write data to register bank
qaddra  input  AW  lookup address A (decode operand A)
qaddrb  input  AW  lookup address B (decode operand B)
qhita  output  1  pending write to qaddra exists
qdataa  output  DW  youngest pending data for qaddra
qhitb  output  1  pending write to qaddrb exists
qdatab  output  DW  youngest pending data for qaddrb
count  output  clog2(DEPTH)+1  current number of queued entries

Behaviour:
- Queue state
  - Circular buffer with head/tail pointers and count register.
  - Reset (async, any time, including mid-drain) sets count=0 and pointers=0. Outputs immediately become enc=0, addrc=0, datac=0, qhita=qhitb=0, qdataa=qdatab=0.
- Acceptance (combinational from registered count plus mem_valid)
  - mem_ready = (count < DEPTH).
  - alu_ready = (count < DEPTH-1) OR (count == DEPTH-1 AND NOT mem_valid).
  - When count == DEPTH, both readies are 0.
  - Readies do not account for the same-cycle dequeue; a full queue stalls both producers for that cycle.
  - Readies are never derived from alu_valid, so no combinational loop with producers.
- Enqueue order when both accepted in one edge: mem entry first (older), then ALU entry.
- Register 0: a handshake to address 0 completes normally (ready honoured) but nothing is enqueued and count is unchanged. Register 0 never appears on addrc.
- Drain
  - enc = (count != 0); addrc/datac = head entry, combinational from queue storage.
  - When enc=0, addrc=0 and datac=0.
  - At every rising edge with count != 0, head advances by one; the bank captures the same entry on that edge.
- Latency: an entry accepted at edge N into an empty queue drives enc=1 during cycle N..N+1 and is written into the bank at edge N+1.
- Count update per edge: count_next = count + enq_num − deq (enq_num 0..2, deq 0..1). Simultaneous enqueue and dequeue at full is impossible because readies are 0.
- Pointers wrap modulo DEPTH.
- Same-address entries stay in order; the bank receives them in acceptance order, so the last accepted value wins.
- Lookup
  - Combinational search over valid entries, youngest to oldest; the first match supplies qdata*.
  - Address 0 never hits.
  - An entry being dequeued in the current cycle still hits, since it is still present before the edge.
  - Entries accepted in the current cycle are not visible until after the edge.

Optional Feature:
- WB_BYPASS_EN defined: lookup logic present as described.
- Not defined: qhita=qhitb=0 and qdataa=qdatab=0 constantly, and no search logic is built. The decode stage must then stall on pending writes.

Test Plan:
- Single write: reset, then alu_valid with addr=5, data=0xDEADBEEF for one cycle. Next cycle enc=1, addrc=5, datac=0xDEADBEEF, count=1. The cycle after, enc=0, count=0.
- Dual accept ordering: with the queue empty, apply in the same cycle mem (addr=3, 0x11) and alu (addr=3, 0x22). Bank sees addr 3 with 0x11, then addr 3 with 0x22 on consecutive edges. During the first drain cycle, qaddra=3 gives qhita=1, qdataa=0x22.
- Fill/backpressure: hold alu_valid with addrs 1..6 and no drain benefit. At count=3 with mem_valid=1, alu_ready=0 and mem_ready=1. At count=4 both readies are 0. Drain order 1,2,3,... with no loss or duplication.
- Zero register: alu_valid addr=0, data=0x55. alu_ready=1, count stays 0, enc never asserts, qaddra=0 gives qhita=0.
- Async reset mid-drain: queue 3 entries, assert reset between edges. enc drops to 0 without a clock edge, count=0. After release, queue is empty and the next write is accepted normally.
- Pointer wrap: stream 10 alternating mem/alu entries (addrs 1..10, data = addr×0x100). Bank receives all 10 in order; count never exceeds DEPTH.
